borrow_select_subtractor: RTL and testbench
===========================================

// Module: borrow_select_subtractor
// PURPOSE
//  Pipelined 32-bit subtractor: diff = a - b - b_in, with borrow and zero flags.
//  It is the subtraction counterpart of the carry-select adder in the ALU datapath and serves SUB/SUBU/SLT/BEQ.
//  Each 4-bit nibble computes both borrow options in parallel, and the incoming borrow selects one.
//  Work is split across pipeline stages behind a valid/ready handshake.
// PARAMETERS
//  WIDTH   32  operand width; must be a multiple of 4*STAGES
//  STAGES  2   pipeline depth; allowed values are 1, 2, 4 and 8; each stage resolves WIDTH/STAGES bits
// PORTS
//  clock      in   1      single clock, rising edge
//  reset      in   1      synchronous, active-high
//  in_valid   in   1      operands present
//  in_ready   out  1      block accepts operands this cycle
//  a          in   WIDTH  minuend
//  b          in   WIDTH  subtrahend
//  b_in       in   1      borrow in (1 = subtract one more)
//  out_valid  out  1      result present
//  out_ready  in   1      consumer takes result this cycle
//  diff       out  WIDTH  a - b - b_in, modulo 2^WIDTH
//  b_out      out  1      borrow out; 1 iff unsigned a < b + b_in
//  zero       out  1      diff == 0
// BEHAVIOUR
//  - Interface: one clock; reset is synchronous and active-high.
//  - Handshake:
//    - A transfer occurs on a rising edge where valid && ready.
//    - in_ready = !(out_valid && !out_ready); the whole pipe stalls as one.
//    - No bubbles are inserted while the pipe is not stalled.
//  - Latency: a result for operands accepted at edge N is out_valid after edge N+STAGES, if no stall occurs.
//    - Full throughput: 1 op/cycle.
//  - Pipeline state: each stage register holds valid, the partial diff, the running borrow, the partial zero, and the unresolved upper operand bits.
//    - Stage k resolves bits [(k+1)*W/S-1 : k*W/S].
//    - Within a stage, the nibble borrow-select chain is combinational.
//  - Nibble math: d0 = a - b with borrow-in 0; d1 = a - b - 1. The running borrow selects both diff and borrow-out.
//  - Borrow convention: borrow = NOT carry of a + ~b + ~b_in.
//  - Flags:
//    - zero is the AND of the per-stage nibble-zero terms.
//    - b_out comes from the top nibble.
//    - Both flags are valid only while out_valid = 1.
//  - Outputs while out_valid = 0: diff, b_out and zero hold their last value.
//  - Reset:
//    - All stage valid bits clear; out_valid = 0; diff = 0; b_out = 0; zero = 0; in_ready = 1 in the cycle after reset.
//    - Reset mid-operation discards in-flight results silently.
//  - Stall: while out_valid && !out_ready, every stage register holds and in_ready = 0.
//    - Operands offered during a stall are not captured.
//  - Simultaneous events: a pop and a push in the same cycle are legal and keep full throughput. Reset overrides any handshake.
//  - Wrap-around: 0x0000_0000 - 1 gives 0xFFFF_FFFF with b_out = 1.
// CONFIGURATION
//  SUB_OVF_FLAG_EN defined:
//    - Adds output port ovf (1 bit): signed overflow = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]).
//    - The sign bits are carried down the pipe.
//    - ovf resets to 0 and follows the same valid/hold rules as the other flags.
//  SUB_OVF_FLAG_EN undefined: no ovf port and no sign-bit pipeline registers.
// STRUCTURE
//  - Shared package alu_pkg:
//    - localparam NIBBLE_W = 4;
//    - typedef struct stage_t {valid, diff, borrow, zero, a_hi, b_hi};
//    - function nib_borrow_select.
//  - One sub-module, borrow_select_nibble:
//    - Inputs a[3:0], b[3:0], bin.
//    - Outputs d[3:0], bout, z.
//    - Combinational, with dual-borrow compute and a 2:1 select.
//    - Instantiated WIDTH/4 times via generate.
//  - Top level holds the stage registers, the stall logic and the flag muxing only.
// TESTING
//  1. Reset, then a = 0x0000_000A, b = 0x0000_0003, b_in = 0.
//     -> After STAGES edges: diff = 0x0000_0007, b_out = 0, zero = 0.
//  2. a = 0x0000_0000, b = 0x0000_0001, b_in = 0.
//     -> diff = 0xFFFF_FFFF, b_out = 1. With SUB_OVF_FLAG_EN: ovf = 0.
//  3. a = 0x1234_5678, b = 0x1234_5677, b_in = 1.
//     -> diff = 0x0000_0000, zero = 1, b_out = 0.
//  4. With SUB_OVF_FLAG_EN: a = 0x8000_0000, b = 0x0000_0001.
//     -> diff = 0x7FFF_FFFF, ovf = 1, b_out = 0.
//  5. Back-to-back stream of 16 random ops with out_ready held low for 3 cycles mid-stream.
//     -> in_ready = 0 during the stall; no op lost or duplicated; order preserved; all diffs match the reference model.
//  6. Accept 2 ops, then assert reset for 1 cycle.
//     -> out_valid = 0 and diff = 0 after reset; no stale result ever appears; the next op completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions for the borrow-select subtractor:
// nibble width, the pipeline stage record and the nibble borrow-select helper.
package alu_pkg;

  localparam int NIBBLE_W = 4;
  localparam int SUB_W    = 32;

  // One pipeline stage record. a_hi/b_hi hold only the operand bits that
  // later stages still have to resolve, shifted down to bit 0.
  typedef struct packed {
    logic             valid;
    logic [SUB_W-1:0] diff;
    logic             borrow;
    logic             zero;
    logic [SUB_W-1:0] a_hi;
    logic [SUB_W-1:0] b_hi;
  } stage_t;

  // Result of one nibble subtraction: difference plus borrow out.
  typedef struct packed {
    logic [NIBBLE_W-1:0] d;
    logic                bout;
  } nib_res_t;

  // Pick between the borrow-in=0 and borrow-in=1 precomputed nibble results.
  function automatic nib_res_t nib_borrow_select(input nib_res_t opt0,
                                                 input nib_res_t opt1,
                                                 input logic     sel);
    return sel ? opt1 : opt0;
  endfunction

endpackage

// File: rtl/borrow_select_subtractor_if.sv
// Handshake and data bundle for the borrow-select subtractor.
// The ovf signal only exists when SUB_OVF_FLAG_EN is defined.
interface borrow_select_subtractor_if
  import alu_pkg::*;
#(
  parameter int WIDTH = SUB_W
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             b_out;
  logic             zero;
`ifdef SUB_OVF_FLAG_EN
  logic             ovf;
`endif

  // Producer/consumer side (drives operands, accepts results)
  modport master (
    output in_valid, a, b, b_in, out_ready,
`ifdef SUB_OVF_FLAG_EN
    input  ovf,
`endif
    input  in_ready, out_valid, diff, b_out, zero
  );

  // Subtractor side
  modport slave (
    input  in_valid, a, b, b_in, out_ready,
`ifdef SUB_OVF_FLAG_EN
    output ovf,
`endif
    output in_ready, out_valid, diff, b_out, zero
  );

endinterface

// File: rtl/borrow_select_nibble.sv
// Combinational 4-bit borrow-select cell: computes a-b and a-b-1 in parallel
// and lets the incoming borrow choose the difference and borrow out.
module borrow_select_nibble
  import alu_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                bin,
  output logic [NIBBLE_W-1:0] d,
  output logic                bout,
  output logic                z
);

  logic [NIBBLE_W:0] w_sub0;
  logic [NIBBLE_W:0] w_sub1;
  nib_res_t          w_opt0;
  nib_res_t          w_opt1;
  nib_res_t          w_sel;

  // The extra top bit of each 5-bit result is the borrow out of the nibble.
  assign w_sub0 = {1'b0, a} - {1'b0, b};
  assign w_sub1 = {1'b0, a} - {1'b0, b} - {{NIBBLE_W{1'b0}}, 1'b1};

  assign w_opt0 = '{d: w_sub0[NIBBLE_W-1:0], bout: w_sub0[NIBBLE_W]};
  assign w_opt1 = '{d: w_sub1[NIBBLE_W-1:0], bout: w_sub1[NIBBLE_W]};
  assign w_sel  = nib_borrow_select(w_opt0, w_opt1, bin);

  assign d    = w_sel.d;
  assign bout = w_sel.bout;
  assign z    = (w_sel.d == '0);

endmodule

// File: rtl/borrow_select_subtractor.sv
// Pipelined borrow-select subtractor: diff = a - b - b_in with borrow and zero
// flags. Each of STAGES stages resolves WIDTH/STAGES bits through a chain of
// borrow_select_nibble cells; an output register holds the final result.
// Define SUB_OVF_FLAG_EN to add the signed-overflow flag (bus.ovf) and the
// sign-bit pipeline that feeds it.
module borrow_select_subtractor
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input logic clock,
  input logic reset,
  borrow_select_subtractor_if.slave bus
);

  localparam int SLICE_W       = WIDTH / STAGES;
  localparam int NIB_PER_STAGE = SLICE_W / NIBBLE_W;

  if ((WIDTH != SUB_W) || ((WIDTH % (NIBBLE_W * STAGES)) != 0) ||
      !((STAGES == 1) || (STAGES == 2) || (STAGES == 4) || (STAGES == 8))) begin : g_badCfg
    $error("borrow_select_subtractor: unsupported WIDTH/STAGES combination");
  end

  stage_t w_in;
  stage_t w_res  [STAGES];
  stage_t r_pipe [STAGES];
  stage_t w_last;
  logic   w_advance;

  logic             r_outValid;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_zero;

  // The whole pipe moves together unless a held result is being refused.
  assign w_advance = !(r_outValid && !bus.out_ready);
  assign w_last    = r_pipe[STAGES-1];

  // Package the incoming operands as an empty stage-0 source record.
  always_comb begin
    w_in        = '0;
    w_in.valid  = bus.in_valid;
    w_in.borrow = bus.b_in;
    w_in.zero   = 1'b1;
    w_in.a_hi   = bus.a;
    w_in.b_hi   = bus.b;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t                   w_src;
    stage_t                   w_stageOut;
    logic [NIB_PER_STAGE:0]   w_chain;
    logic [SLICE_W-1:0]       w_sliceDiff;
    logic [NIB_PER_STAGE-1:0] w_nibZero;

    if (k == 0) begin : g_first
      assign w_src = w_in;
    end else begin : g_next
      assign w_src = r_pipe[k-1];
    end

    assign w_chain[0] = w_src.borrow;

    for (genvar j = 0; j < NIB_PER_STAGE; j++) begin : g_nib
      borrow_select_nibble u_nib (
        .a    (w_src.a_hi[j*NIBBLE_W +: NIBBLE_W]),
        .b    (w_src.b_hi[j*NIBBLE_W +: NIBBLE_W]),
        .bin  (w_chain[j]),
        .d    (w_sliceDiff[j*NIBBLE_W +: NIBBLE_W]),
        .bout (w_chain[j+1]),
        .z    (w_nibZero[j])
      );
    end

    // Merge this stage's slice into the running result and drop the consumed operand bits.
    always_comb begin
      w_stageOut                            = w_src;
      w_stageOut.diff[k*SLICE_W +: SLICE_W] = w_sliceDiff;
      w_stageOut.borrow                     = w_chain[NIB_PER_STAGE];
      w_stageOut.zero                       = w_src.zero & (&w_nibZero);
      w_stageOut.a_hi                       = w_src.a_hi >> SLICE_W;
      w_stageOut.b_hi                       = w_src.b_hi >> SLICE_W;
    end

    assign w_res[k] = w_stageOut;
  end

  // Stage registers: flush on reset, shift forward whenever the pipe is not stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        r_pipe[k] <= '0;
      end
    end else if (w_advance) begin
      for (int k = 0; k < STAGES; k++) begin
        r_pipe[k] <= w_res[k];
      end
    end
  end

  // Output register: result data only updates when a valid result arrives, so it holds otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_outValid <= 1'b0;
      r_diff     <= '0;
      r_bout     <= 1'b0;
      r_zero     <= 1'b0;
    end else if (w_advance) begin
      r_outValid <= w_last.valid;
      if (w_last.valid) begin
        r_diff <= w_last.diff[WIDTH-1:0];
        r_bout <= w_last.borrow;
        r_zero <= w_last.zero;
      end
    end
  end

`ifdef SUB_OVF_FLAG_EN
  logic [1:0] r_sign [STAGES];
  logic       r_ovf;
  logic       w_ovf;

  assign w_ovf = (r_sign[STAGES-1][1] != r_sign[STAGES-1][0]) &&
                 (w_last.diff[WIDTH-1] != r_sign[STAGES-1][1]);

  // Carry the operand sign bits alongside the stage registers ({a sign, b sign}).
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        r_sign[k] <= 2'b00;
      end
    end else if (w_advance) begin
      r_sign[0] <= {bus.a[WIDTH-1], bus.b[WIDTH-1]};
      for (int k = 1; k < STAGES; k++) begin
        r_sign[k] <= r_sign[k-1];
      end
    end
  end

  // Overflow flag follows the same capture/hold rules as the other result flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_advance && w_last.valid) begin
      r_ovf <= w_ovf;
    end
  end

  assign bus.ovf = r_ovf;
`endif

  // The last stage has shifted out all operand bits; nothing downstream reads them.
  logic w_unusedOps;
  assign w_unusedOps = ^{w_last.a_hi, w_last.b_hi};

  assign bus.in_ready  = w_advance;
  assign bus.out_valid = r_outValid;
  assign bus.diff      = r_diff;
  assign bus.b_out     = r_bout;
  assign bus.zero      = r_zero;

endmodule

// File: tb/tb_borrow_select_subtractor.sv
// Directed testbench for borrow_select_subtractor (STAGES = 2).
// Build with SUB_OVF_FLAG_EN defined to also exercise the overflow flag.
module tb_borrow_select_subtractor;

  localparam int WIDTH  = 32;
  localparam int STAGES = 2;

  logic clock = 1'b0;
  logic reset;

  int totalChecks = 0;
  int badChecks   = 0;

  borrow_select_subtractor_if #(.WIDTH(WIDTH)) bus ();

  borrow_select_subtractor #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clock = ~clock;

  // Hard stop in case something hangs
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Count one comparison and report it if the observed value is wrong
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one set of operands onto the input side of the bus
  task automatic applyStimulus(input logic valid, input logic [31:0] aVal,
                               input logic [31:0] bVal, input logic binVal);
    bus.in_valid = valid;
    bus.a        = aVal;
    bus.b        = bVal;
    bus.b_in     = binVal;
  endtask

  // Send one op, wait (bounded) for its result and check latency, value, flags and hold
  task automatic runSingle(input string tag, input logic [31:0] aVal,
                           input logic [31:0] bVal, input logic binVal,
                           input logic [31:0] expDiff, input logic expBout,
                           input logic expZero);
    int cyc;
    @(negedge clock);
    bus.out_ready = 1'b1;
    applyStimulus(1'b1, aVal, bVal, binVal);
    #1;
    checkOutput($sformatf("%s_in_ready", tag), bus.in_ready, 1);
    @(negedge clock);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
    cyc = 1;
    while (!bus.out_valid && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    checkOutput($sformatf("%s_out_valid", tag), bus.out_valid, 1);
    checkOutput($sformatf("%s_latency", tag), cyc, STAGES + 1);
    checkOutput($sformatf("%s_diff", tag), bus.diff, expDiff);
    checkOutput($sformatf("%s_b_out", tag), bus.b_out, expBout);
    checkOutput($sformatf("%s_zero", tag), bus.zero, expZero);
    @(negedge clock);
    checkOutput($sformatf("%s_valid_drop", tag), bus.out_valid, 0);
    checkOutput($sformatf("%s_diff_hold", tag), bus.diff, expDiff);
  endtask

  logic [31:0] opA   [16];
  logic [31:0] opB   [16];
  logic        opBin [16];
  logic [34:0] expQ  [$];

  initial begin
    int          sent;
    int          got;
    int          cyc;
    int          stallSeen;
    logic        staleSeen;
    logic [32:0] full;
    logic [34:0] expRec;
    logic        expOvf;

    reset         = 1'b1;
    bus.out_ready = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("reset_out_valid", bus.out_valid, 0);
    checkOutput("reset_diff", bus.diff, 0);
    checkOutput("reset_b_out", bus.b_out, 0);
    checkOutput("reset_zero", bus.zero, 0);
    checkOutput("reset_in_ready", bus.in_ready, 1);
`ifdef SUB_OVF_FLAG_EN
    checkOutput("reset_ovf", bus.ovf, 0);
`endif

    // Plain subtraction, no borrow
    runSingle("t1", 32'h0000_000A, 32'h0000_0003, 1'b0, 32'h0000_0007, 1'b0, 1'b0);

    // Wrap-around below zero
    runSingle("t2", 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
`ifdef SUB_OVF_FLAG_EN
    checkOutput("t2_ovf", bus.ovf, 0);
`endif

    // Borrow-in makes the result exactly zero
    runSingle("t3", 32'h1234_5678, 32'h1234_5677, 1'b1, 32'h0000_0000, 1'b0, 1'b1);

`ifdef SUB_OVF_FLAG_EN
    // Most negative minus one overflows to positive
    runSingle("t4", 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0);
    checkOutput("t4_ovf", bus.ovf, 1);
`endif

    // Borrow ripples across every nibble and both stages
    runSingle("t_ripple", 32'h0001_0000, 32'h0000_0001, 1'b1, 32'h0000_FFFE, 1'b0, 1'b0);

    // Back-to-back stream with a 3-cycle consumer stall mid-stream
    for (int i = 0; i < 16; i++) begin
      opA[i]   = $urandom;
      opB[i]   = $urandom;
      opBin[i] = 1'($urandom_range(0, 1));
    end
    sent      = 0;
    got       = 0;
    cyc       = 0;
    stallSeen = 0;
    while (got < 16 && cyc < 300) begin
      @(negedge clock);
      cyc++;
      bus.out_ready = !(cyc >= 8 && cyc <= 10);
      if (sent < 16) begin
        applyStimulus(1'b1, opA[sent], opB[sent], opBin[sent]);
      end else begin
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
      end
      #1;
      if (!bus.in_ready) begin
        stallSeen++;
      end
      if (cyc >= 8 && cyc <= 10) begin
        checkOutput($sformatf("stall_in_ready_c%0d", cyc), bus.in_ready, 0);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("stream_spurious", bus.out_valid, 0);
        end else begin
          expRec = expQ.pop_front();
          checkOutput($sformatf("stream_diff_%0d", got), bus.diff, expRec[31:0]);
          checkOutput($sformatf("stream_b_out_%0d", got), bus.b_out, expRec[32]);
          checkOutput($sformatf("stream_zero_%0d", got), bus.zero, (expRec[31:0] == 32'h0));
`ifdef SUB_OVF_FLAG_EN
          checkOutput($sformatf("stream_ovf_%0d", got), bus.ovf, expRec[33]);
`endif
          got++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        full   = {1'b0, opA[sent]} - {1'b0, opB[sent]} - {32'h0, opBin[sent]};
        expOvf = (opA[sent][31] != opB[sent][31]) && (full[31] != opA[sent][31]);
        expQ.push_back({1'b0, expOvf, full[32], full[31:0]});
        sent++;
      end
    end
    checkOutput("stream_count", got, 16);
    checkOutput("stream_stall_cycles", stallSeen, 3);
    checkOutput("stream_cycles", cyc, 19 + STAGES + 1);
    @(negedge clock);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
    bus.out_ready = 1'b1;

    // Accept two ops, then reset before either result emerges
    @(negedge clock);
    applyStimulus(1'b1, 32'h0000_0005, 32'h0000_0002, 1'b0);
    @(negedge clock);
    applyStimulus(1'b1, 32'h0000_0009, 32'h0000_0001, 1'b0);
    @(negedge clock);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("rst6_out_valid", bus.out_valid, 0);
    checkOutput("rst6_diff", bus.diff, 0);
    checkOutput("rst6_b_out", bus.b_out, 0);
    checkOutput("rst6_in_ready", bus.in_ready, 1);
    staleSeen = 1'b0;
    repeat (6) begin
      @(negedge clock);
      staleSeen = staleSeen | bus.out_valid;
    end
    checkOutput("rst6_no_stale", staleSeen, 0);
    runSingle("rst6_next", 32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
